// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: EX/MEM/WB scoreboard, forwarding selects, load-use stall, redirect flush, freeze.
// Optional performance counters (stall_cnt, flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_dec,
    input  logic [4:0]  rs1_dec,
    input  logic [4:0]  rs2_dec,
    input  logic [4:0]  rd_dec,
    input  logic        rf_wb_dec,
    input  logic        mem_load_dec,
    input  logic        redirect_ex,
    input  logic        mem_busy,
    output logic [3:0]  RAW_hazards,
    output logic [1:0]  RAW_mem_wb_hazards,
    output logic        we_valid,
    output logic        stall_if,
    output logic        stall_dec,
    output logic        bubble_ex,
    output logic        flush_dec,
    output logic        freeze
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } sb_entry_t;

    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    sb_entry_t sb_reg [3];
    sb_entry_t ex_next;

    // hit[stage][src]: src 0 = rs1, src 1 = rs2
    logic [1:0] hit [3];
    logic [1:0] fwd_ex;
    logic [1:0] fwd_mem;
    logic [1:0] ld_wb;
    logic [1:0] ld_use;
    logic       load_stall;
    logic       bubble_int;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stage
            logic live;
            assign live = sb_reg[gi].v & sb_reg[gi].we & (sb_reg[gi].rd != 5'd0);
            assign hit[gi][0] = live & (sb_reg[gi].rd == rs1_dec);
            assign hit[gi][1] = live & (sb_reg[gi].rd == rs2_dec);
        end
        // Youngest producer wins: an older stage only flags when no younger stage matches.
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign fwd_ex[gi]  = hit[EX][gi] & ~sb_reg[EX].ld;
            assign fwd_mem[gi] = hit[MEM][gi] & ~sb_reg[MEM].ld & ~hit[EX][gi];
            assign ld_wb[gi]   = hit[WB][gi] & sb_reg[WB].ld & ~hit[EX][gi] & ~hit[MEM][gi];
            assign ld_use[gi]  = (hit[EX][gi] & sb_reg[EX].ld) | (hit[MEM][gi] & sb_reg[MEM].ld);
        end
    endgenerate

    assign load_stall = valid_dec & (|ld_use);
    assign bubble_int = redirect_ex | load_stall;

    always_comb begin
        ex_next    = '0;
        ex_next.v  = valid_dec & ~bubble_int;
        ex_next.rd = rd_dec;
        ex_next.we = rf_wb_dec;
        ex_next.ld = mem_load_dec;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                sb_reg[i] <= '0;
            end
        end else if (!mem_busy) begin
            sb_reg[WB]  <= sb_reg[MEM];
            sb_reg[MEM] <= sb_reg[EX];
            sb_reg[EX]  <= ex_next;
        end
    end

    // Priority freeze > redirect > load stall; everything is held low during reset.
    always_comb begin
        RAW_hazards        = 4'b0000;
        RAW_mem_wb_hazards = 2'b00;
        we_valid           = 1'b0;
        stall_if           = 1'b0;
        stall_dec          = 1'b0;
        bubble_ex          = 1'b0;
        flush_dec          = 1'b0;
        freeze             = 1'b0;
        if (rst) begin
            RAW_hazards        = {fwd_ex[0], fwd_ex[1], fwd_mem[0], fwd_mem[1]};
            RAW_mem_wb_hazards = {ld_wb[0], ld_wb[1]};
            we_valid           = sb_reg[WB].v;
            freeze             = mem_busy;
            if (mem_busy) begin
                stall_if  = 1'b1;
                stall_dec = 1'b1;
            end else if (redirect_ex) begin
                flush_dec = 1'b1;
                bubble_ex = 1'b1;
            end else if (load_stall) begin
                stall_if  = 1'b1;
                stall_dec = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else if (!mem_busy) begin
            if (redirect_ex) begin
                if (flush_cnt_reg != 32'hFFFF_FFFF) flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end else if (load_stall) begin
                if (stall_cnt_reg != 32'hFFFF_FFFF) stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random traffic against an instruction-level model.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        valid_dec;
    logic [4:0]  rs1_dec, rs2_dec, rd_dec;
    logic        rf_wb_dec, mem_load_dec, redirect_ex, mem_busy;
    logic [3:0]  RAW_hazards;
    logic [1:0]  RAW_mem_wb_hazards;
    logic        we_valid, stall_if, stall_dec, bubble_ex, flush_dec, freeze;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst), .valid_dec(valid_dec),
        .rs1_dec(rs1_dec), .rs2_dec(rs2_dec), .rd_dec(rd_dec),
        .rf_wb_dec(rf_wb_dec), .mem_load_dec(mem_load_dec),
        .redirect_ex(redirect_ex), .mem_busy(mem_busy),
        .RAW_hazards(RAW_hazards), .RAW_mem_wb_hazards(RAW_mem_wb_hazards),
        .we_valid(we_valid), .stall_if(stall_if), .stall_dec(stall_dec),
        .bubble_ex(bubble_ex), .flush_dec(flush_dec), .freeze(freeze)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    // Model: in-flight instructions, index 0 = youngest (EX), 2 = oldest (WB)
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       we;
        bit       ld;
    } ent_t;
    ent_t pipe [3];
    bit [31:0] m_stall = 0;
    bit [31:0] m_flush = 0;

    logic [3:0] e_raw;
    logic [1:0] e_mwb;
    logic e_wev, e_sif, e_sdec, e_bub, e_flush, e_frz, e_ls, e_kill;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
        end
    endtask

    function automatic bit writes(input int k, input bit [4:0] rs);
        return pipe[k].v && pipe[k].we && pipe[k].rd != 5'd0 && pipe[k].rd == rs;
    endfunction

    function automatic int youngest(input bit [4:0] rs);
        for (int k = 0; k < 3; k++) if (writes(k, rs)) return k;
        return -1;
    endfunction

    task automatic compute_expected();
        bit [4:0] src [2];
        bit [1:0] fex, fmem, fwb;
        int p;
        src[0] = rs1_dec;
        src[1] = rs2_dec;
        fex = 0; fmem = 0; fwb = 0; e_ls = 0;
        for (int s = 0; s < 2; s++) begin
            p = youngest(src[s]);
            if (p == 0 && !pipe[0].ld) fex[s] = 1;
            if (p == 1 && !pipe[1].ld) fmem[s] = 1;
            if (p == 2 && pipe[2].ld) fwb[s] = 1;
            for (int k = 0; k < 2; k++) if (writes(k, src[s]) && pipe[k].ld) e_ls = 1;
        end
        e_ls = e_ls & valid_dec;
        e_kill = redirect_ex | e_ls;
        {e_raw, e_mwb, e_wev, e_sif, e_sdec, e_bub, e_flush, e_frz} = '0;
        if (rst) begin
            e_raw = {fex[0], fex[1], fmem[0], fmem[1]};
            e_mwb = {fwb[0], fwb[1]};
            e_wev = pipe[2].v;
            e_frz = mem_busy;
            if (mem_busy) begin
                e_sif = 1; e_sdec = 1;
            end else if (redirect_ex) begin
                e_flush = 1; e_bub = 1;
            end else if (e_ls) begin
                e_sif = 1; e_sdec = 1; e_bub = 1;
            end
        end
    endtask

    task automatic update_model();
        if (!rst) begin
            for (int k = 0; k < 3; k++) pipe[k].v = 0;
            m_stall = 0;
            m_flush = 0;
        end else if (!mem_busy) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0].v  = valid_dec && !e_kill;
            pipe[0].rd = rd_dec;
            pipe[0].we = rf_wb_dec;
            pipe[0].ld = mem_load_dec;
            if (redirect_ex) begin
                if (m_flush != 32'hFFFF_FFFF) m_flush++;
            end else if (e_ls) begin
                if (m_stall != 32'hFFFF_FFFF) m_stall++;
            end
        end
    endtask

    task automatic drive(input bit v, input bit [4:0] r1, input bit [4:0] r2, input bit [4:0] rd,
                         input bit we, input bit ld, input bit red, input bit busy);
        valid_dec = v; rs1_dec = r1; rs2_dec = r2; rd_dec = rd;
        rf_wb_dec = we; mem_load_dec = ld; redirect_ex = red; mem_busy = busy;
        #1;
    endtask

    // Compare every output with the model mid-cycle, then clock and advance the model.
    task automatic cyc();
        #2;
        compute_expected();
        check("raw_hazards", {28'd0, RAW_hazards}, {28'd0, e_raw});
        check("raw_mem_wb", {30'd0, RAW_mem_wb_hazards}, {30'd0, e_mwb});
        check("we_valid", {31'd0, we_valid}, {31'd0, e_wev});
        check("stall_if", {31'd0, stall_if}, {31'd0, e_sif});
        check("stall_dec", {31'd0, stall_dec}, {31'd0, e_sdec});
        check("bubble_ex", {31'd0, bubble_ex}, {31'd0, e_bub});
        check("flush_dec", {31'd0, flush_dec}, {31'd0, e_flush});
        check("freeze", {31'd0, freeze}, {31'd0, e_frz});
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
`endif
        $display("[TB] cyc %0d rst=%0b v=%0b rs=%0d/%0d rd=%0d red=%0b busy=%0b raw=%b mwb=%b stall=%0b bub=%0b flush=%0b",
                 cycle, rst, valid_dec, rs1_dec, rs2_dec, rd_dec, redirect_ex, mem_busy,
                 RAW_hazards, RAW_mem_wb_hazards, stall_dec, bubble_ex, flush_dec);
        @(posedge clk);
        update_model();
        cycle++;
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            cyc();
        end
    endtask

    initial begin
        bit [31:0] fl_before, st_before;
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
        rst = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_stall_dec", {31'd0, stall_dec}, 32'd0);
        check("reset_we_valid", {31'd0, we_valid}, 32'd0);
        cyc();
        cyc();
        rst = 1;
        nops(1);

        // ALU chain
        drive(1, 0, 0, 5, 1, 0, 0, 0); cyc();
        drive(1, 5, 0, 0, 0, 0, 0, 0);
        check("alu_ex_fwd", {28'd0, RAW_hazards}, 32'b1000);
        check("alu_no_stall", {31'd0, stall_dec}, 32'd0);
        cyc();
        drive(1, 5, 0, 0, 0, 0, 0, 0);
        check("alu_mem_fwd", {28'd0, RAW_hazards}, 32'b0010);
        cyc();

        // Load-use
        nops(3);
        drive(1, 0, 0, 7, 1, 1, 0, 0); cyc();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 7, 8, 1, 0, 0, 0);
            check("lu_stall_dec", {31'd0, stall_dec}, 32'd1);
            check("lu_bubble", {31'd0, bubble_ex}, 32'd1);
            cyc();
        end
        drive(1, 0, 7, 8, 1, 0, 0, 0);
        check("lu_release", {31'd0, stall_dec}, 32'd0);
        check("lu_wb_flag", {30'd0, RAW_mem_wb_hazards}, 32'b01);
        cyc();

        // Youngest producer
        nops(3);
        drive(1, 0, 0, 3, 1, 1, 0, 0); cyc();
        nops(1);
        drive(1, 0, 0, 3, 1, 0, 0, 0); cyc();
        drive(1, 3, 0, 0, 0, 0, 0, 0);
        check("young_ex", {31'd0, RAW_hazards[3]}, 32'd1);
        check("young_wb", {31'd0, RAW_mem_wb_hazards[1]}, 32'd0);
        cyc();

        // x0 sources with x0 writers in flight
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 1, i == 1, 0, 0); cyc();
        end
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        check("x0_raw", {28'd0, RAW_hazards}, 32'd0);
        check("x0_mwb", {30'd0, RAW_mem_wb_hazards}, 32'd0);
        check("x0_stall", {31'd0, stall_dec}, 32'd0);
        cyc();

        // Redirect during load stall
        nops(3);
        drive(1, 0, 0, 9, 1, 1, 0, 0); cyc();
        drive(1, 9, 0, 0, 0, 0, 1, 0);
        check("redir_flush", {31'd0, flush_dec}, 32'd1);
        check("redir_stall_if", {31'd0, stall_if}, 32'd0);
        check("redir_bubble", {31'd0, bubble_ex}, 32'd1);
        fl_before = m_flush;
        st_before = m_stall;
        cyc();
`ifdef HAZARD_PERF_CNT_EN
        check("redir_flush_cnt", flush_cnt, fl_before + 32'd1);
        check("redir_stall_cnt", stall_cnt, st_before);
`endif

        // Freeze for 3 cycles, then reset in the middle of the freeze
        nops(3);
        drive(1, 0, 0, 4, 1, 0, 0, 0); cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1, 4, 0, 0, 0, 0, 0, 1);
            check("frz_freeze", {31'd0, freeze}, 32'd1);
            check("frz_hold", {28'd0, RAW_hazards}, 32'b1000);
            check("frz_stall_if", {31'd0, stall_if}, 32'd1);
            cyc();
        end
        rst = 0;
        drive(1, 4, 0, 0, 0, 0, 1, 1);
        check("rst_frz_freeze", {31'd0, freeze}, 32'd0);
        check("rst_frz_stall", {31'd0, stall_if}, 32'd0);
        check("rst_frz_raw", {28'd0, RAW_hazards}, 32'd0);
        cyc();
        rst = 1;
        drive(1, 4, 0, 0, 0, 0, 0, 0);
        check("post_rst_clear", {28'd0, RAW_hazards}, 32'd0);
        cyc();

        // Random traffic on a small register set so hazards are frequent
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 49) != 0);
            drive($urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It keeps a registered scoreboard of the EX, MEM and WB instructions (valid, rd, write-enable, is-load) and compares it against the decode-stage source registers. From that comparison it drives the decode forwarding-select buses, load-use stalls, branch/jump flush bubbles and whole-pipeline freeze on data-memory wait. It sits beside the decode stage: it feeds that stage's `RAW_hazards`, `RAW_mem_wb_hazards` and `we_valid` inputs, and its stall/flush outputs feed the IF/DEC and DEC/EX pipeline registers.

## Interface
- No parameters (RV32I, 32 registers, fixed 5-bit addresses).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `valid_dec` in 1: decode holds a real (non-bubble) instruction.
- `rs1_dec`, `rs2_dec` in 5: decode source registers (rs1 already zeroed for LUI).
- `rd_dec` in 5: decode destination register.
- `rf_wb_dec` in 1: decode instruction writes the register file.
- `mem_load_dec` in 1: decode instruction is a load (`wb_src[1]`).
- `redirect_ex` in 1: taken branch or jump resolved in EX this cycle.
- `mem_busy` in 1: data memory not ready; freezes the pipeline.
- `RAW_hazards` out 4: {rs1_ex, rs2_ex, rs1_mem, rs2_mem} forward requests.
- `RAW_mem_wb_hazards` out 2: {rs1, rs2} source produced by a load now in WB.
- `we_valid` out 1: WB scoreboard entry is valid.
- `stall_if`, `stall_dec` out 1: hold PC and the IF/DEC register.
- `bubble_ex` out 1: load a NOP into the DEC/EX register.
- `flush_dec` out 1: invalidate the IF/DEC register.
- `freeze` out 1: hold every pipeline register.
- `stall_cnt`, `flush_cnt` out 32: performance counters, present only with `HAZARD_PERF_CNT_EN`.

## Operation
- **Scoreboard entries.** EX, MEM and WB each hold {v, rd, we, ld}.
- **Live match.** An entry matches source `rsN` when v & we & (rd != 0) & (rd == rsN). rs = x0 never matches.
- **Load-use stall.** `load_stall` = `valid_dec` & (rs1 or rs2 matches an EX or MEM entry with ld = 1).
- **Forward flags.**
  - `rsN_ex` = the EX entry matches with ld = 0.
  - `rsN_mem` = the MEM entry matches with ld = 0 and the EX entry does not match rsN.
- **Load WB flag.** `RAW_mem_wb_hazards[N]` = the WB entry matches with ld = 1 and neither EX nor MEM matches rsN. Youngest producer always wins.
- **Freeze.** `freeze` = `mem_busy`.
  - While frozen: `stall_if` = `stall_dec` = 1, `bubble_ex` = `flush_dec` = 0, scoreboard holds.
- **Redirect** (no freeze, `redirect_ex` = 1): `flush_dec` = 1, `bubble_ex` = 1, `stall_if` = `stall_dec` = 0. Redirect overrides `load_stall`, because the decode instruction is wrong-path.
- **Load stall** (no freeze, no redirect, `load_stall` = 1): `stall_if` = `stall_dec` = `bubble_ex` = 1.
- **Advance** (every non-frozen edge):
  - WB <= MEM, MEM <= EX.
  - EX <= bubble (v = 0) if `bubble_ex` or !`valid_dec`; otherwise {1, `rd_dec`, `rf_wb_dec`, `mem_load_dec`}.
- **Forward flags during stalls.** Flags are still driven during a stall. Decode ignores them because the DEC/EX register receives a bubble.
- **Dependent on a load in EX.** Stalls 2 cycles (load in EX, then in MEM). In the next cycle it sees `RAW_mem_wb_hazards` = 1.

## Timing
- All outputs except the counters are combinational from the registered scoreboard and the current decode inputs. Zero-cycle latency.
- **Reset.** On an edge with `rst` = 0, all scoreboard v, `stall_cnt` and `flush_cnt` clear to 0. While `rst` = 0, all outputs are forced to 0. Reset mid-stall or mid-freeze discards the stall or freeze immediately.
- **Simultaneous events.** Priority is `freeze` > `redirect_ex` > `load_stall`.
- **mem_busy and redirect together.** Both high: the redirect is not acted on. It remains valid once `mem_busy` falls, because the EX entry is held.
- **Simultaneous writer and reader.** A WB non-load entry matching decode raises no flag; decode's internal WB bypass covers it via `we_valid`.

## Configuration
- **`HAZARD_PERF_CNT_EN` defined.**
  - `stall_cnt` increments on each edge with `load_stall` & !`freeze` & !`redirect_ex`.
  - `flush_cnt` increments on each edge with `redirect_ex` & !`freeze`.
  - Both counters saturate at 0xFFFF_FFFF.
- **Undefined.** The counter ports and registers are absent.

## Test plan
- **ALU chain.** `add x5` in EX, decode rs1 = 5 -> `RAW_hazards` = 4'b1000, no stall. Next cycle (now in MEM) -> 4'b0010.
- **Load-use.** `lw x7` in EX, decode rs2 = 7 -> `stall_dec` = `bubble_ex` = 1 for exactly 2 cycles. Third cycle -> `RAW_mem_wb_hazards` = 2'b01, stalls = 0.
- **Youngest producer.** x3 written by a load in WB and by an ALU op in EX, decode rs1 = 3 -> `RAW_hazards[3]` = 1, `RAW_mem_wb_hazards[1]` = 0.
- **x0 source.** rs1 = rs2 = 0 with `rd_dec` = 0 writers in flight -> all flags 0, no stall.
- **Redirect during load stall.** `redirect_ex` = 1 while `load_stall` = 1 -> `flush_dec` = 1, `stall_if` = 0, `flush_cnt` +1, `stall_cnt` unchanged.
- **Freeze.** `mem_busy` high for 3 cycles -> `freeze` = 1 and scoreboard unchanged throughout. Assert `rst` = 0 during the freeze -> all outputs 0 next cycle.
